hms_timekeeper: RTL and testbench
=================================

// Module: hms_timekeeper
// PURPOSE
//   Single-clock, parametrised hour:min:sec timekeeper with N independent alarm channels.
//   Replaces ripple-clocked per-field counters with tick-enable counting and a same-cycle carry chain.
//   Supports field-wise setup editing and edge-qualified sticky alarms with clear.
//   Sits between the 1 Hz tick generator (nco) and the display/buzz logic.
// PARAMETERS
//   CW        6    field width (sec/min/hour registers and outputs)
//   SEC_MAX   59   sec wraps SEC_MAX->0
//   MIN_MAX   59   min wraps MIN_MAX->0
//   HOUR_MAX  23   hour wraps HOUR_MAX->0
//   N_ALARM   2    number of alarm channels (1..4)
//   AW        1    alarm-select width, 2**AW >= N_ALARM
//   SNOOZE_SEC 300 snooze length in ticks (used only with HMS_SNOOZE_EN), 16-bit
// PORTS
//   clk          in   1        system clock; the only clock
//   rst_n        in   1        asynchronous, active-low reset
//   i_tick       in   1        1-cycle 1 Hz enable pulse
//   i_mode       in   2        0 CLOCK, 1 SETUP, 2 ALARM, 3 treated as CLOCK
//   i_position   in   2        0 sec, 1 min, 2 hour, 3 none
//   i_inc        in   1        1-cycle pulse: increment selected field
//   i_alarm_sel  in   AW       alarm channel edited/displayed in MODE_ALARM
//   i_alarm_en   in   N_ALARM  per-channel alarm enable
//   i_alarm_clr  in   1        1-cycle pulse: clear all o_alarm bits
//   i_snooze     in   1        1-cycle pulse: snooze (ignored without HMS_SNOOZE_EN)
//   o_sec/o_min/o_hour out CW  displayed time or alarm[i_alarm_sel] (MODE_ALARM)
//   o_day_hit    out  1        1-cycle pulse on hour wrap HOUR_MAX->0
//   o_alarm      out  N_ALARM  sticky per-channel alarm flags
//   o_alarm_any  out  1        |o_alarm
// BEHAVIOUR
//   - Reset: time, all alarm registers, o_alarm, o_day_hit, snooze state = 0. Display outputs are combinational from registers, so they read 0.
//   - Counting (modes 0,2,3): on i_tick, sec+1. Field at >= its MAX wraps to 0 and carries to the next field in the SAME edge.
//     23:59:59 + tick -> 00:00:00 in one cycle; o_day_hit = 1 on that edge only.
//   - MODE_SETUP: time frozen, i_tick ignored. i_inc increments the field at i_position, wrapping with no carry. Position 3: no effect.
//   - MODE_ALARM: time keeps counting. i_inc edits alarm[i_alarm_sel] at i_position (wrap, no carry). i_alarm_sel >= N_ALARM: no edit; display shows 0.
//   - i_inc in modes 0/3: ignored.
//   - Alarm set: o_alarm[k] <= 1 on the edge after a tick-driven time update makes time == alarm[k] while i_alarm_en[k] = 1.
//     Latency: 1 clk after the time register change. Setup or alarm edits that create equality never fire.
//   - Alarm hold/clear: sticky. Cleared by i_alarm_clr, or per bit by i_alarm_en[k] = 0.
//     Set and clear in the same cycle: set wins. No re-fire while time stays equal after clear.
//   - Reset mid-alarm: all state returns to 0 immediately (async).
// CONFIGURATION
//   HMS_SNOOZE_EN defined:
//     - i_snooze with o_alarm != 0: copy o_alarm into snooze_mask, clear o_alarm, load snooze counter = SNOOZE_SEC.
//     - Counter decrements on i_tick. On reaching 0, o_alarm |= snooze_mask & i_alarm_en, then mask clears.
//     - i_alarm_clr also cancels a pending snooze. i_snooze with o_alarm == 0: no effect.
//   HMS_SNOOZE_EN undefined: no snooze logic. i_snooze port present but ignored; behaviour as above.
// TESTING
//   1. Reset, 59 ticks -> 00:00:59; 60th tick -> 00:01:00 same edge; 3600 ticks from 0 -> 01:00:00.
//   2. SETUP: set 23:59:59, mode 0, one tick -> 00:00:00, o_day_hit high exactly 1 cycle.
//   3. SETUP pos=1, min=59, i_inc -> min=0, hour unchanged; ticks during SETUP leave time unchanged.
//   4. alarm0 = 00:00:05, en=01, 5 ticks -> o_alarm=01 one clk after 5th tick, held. i_alarm_clr -> 00, no re-fire before 6th tick.
//   5. alarm1 = alarm0 = 00:00:03, en=01 -> only o_alarm[0]. Drop en[0] while set -> o_alarm[0]=0. Edit alarm0 to current time in mode 2 -> no fire.
//   6. HMS_SNOOZE_EN, SNOOZE_SEC=3: alarm fires, i_snooze -> o_alarm=0; 3rd tick later -> o_alarm restored. Without macro, i_snooze no effect.

Source files
------------

// File: rtl/hms_timekeeper.sv
// hour:min:sec timekeeper with tick-enable counting, same-edge carry chain and N sticky alarms.
// Optional snooze is built only when HMS_SNOOZE_EN is defined.
module hms_timekeeper #(
  parameter int CW         = 6,
  parameter int SEC_MAX    = 59,
  parameter int MIN_MAX    = 59,
  parameter int HOUR_MAX   = 23,
  parameter int N_ALARM    = 2,
  parameter int AW         = 1,
  parameter int SNOOZE_SEC = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_position,
  input  logic               i_inc,
  input  logic [AW-1:0]      i_alarm_sel,
  input  logic [N_ALARM-1:0] i_alarm_en,
  input  logic               i_alarm_clr,
  input  logic               i_snooze,
  output logic [CW-1:0]      o_sec,
  output logic [CW-1:0]      o_min,
  output logic [CW-1:0]      o_hour,
  output logic               o_day_hit,
  output logic [N_ALARM-1:0] o_alarm,
  output logic               o_alarm_any
);

  typedef struct packed {
    logic [CW-1:0] hour;
    logic [CW-1:0] min;
    logic [CW-1:0] sec;
  } hms_t;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SETUP     = 2'd1,
    MODE_ALARM     = 2'd2,
    MODE_CLOCK_ALT = 2'd3
  } mode_e;

  localparam logic [CW-1:0] SEC_LIM  = CW'(SEC_MAX);
  localparam logic [CW-1:0] MIN_LIM  = CW'(MIN_MAX);
  localparam logic [CW-1:0] HOUR_LIM = CW'(HOUR_MAX);

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
    return (v >= lim) ? '0 : v + 1'b1;
  endfunction

  // Field edit used by both setup and alarm editing: wraps, never carries.
  function automatic hms_t edit_field(input hms_t t, input logic [1:0] pos);
    hms_t r;
    r = t;
    case (pos)
      2'd0:    r.sec  = wrap_inc(t.sec, SEC_LIM);
      2'd1:    r.min  = wrap_inc(t.min, MIN_LIM);
      2'd2:    r.hour = wrap_inc(t.hour, HOUR_LIM);
      default: r = t;
    endcase
    return r;
  endfunction

  mode_e mode;
  assign mode = mode_e'(i_mode);

  hms_t               time_q, time_d;
  hms_t               alarm_q [N_ALARM];
  hms_t               alarm_d [N_ALARM];
  logic               tick_upd_q, tick_upd_d;
  logic               day_hit_q, day_hit_d;
  logic [N_ALARM-1:0] flags_q, flags_d;
  logic               sec_wrap, min_wrap, hour_wrap;

  assign sec_wrap  = time_q.sec >= SEC_LIM;
  assign min_wrap  = sec_wrap && (time_q.min >= MIN_LIM);
  assign hour_wrap = min_wrap && (time_q.hour >= HOUR_LIM);

  // NOTE: combinational next-state uses blocking '=' with a default for every target, so no latch is inferred.
  always_comb begin
    time_d     = time_q;
    tick_upd_d = 1'b0;
    day_hit_d  = 1'b0;
    for (int k = 0; k < N_ALARM; k++) alarm_d[k] = alarm_q[k];

    if (mode == MODE_SETUP) begin
      if (i_inc) time_d = edit_field(time_q, i_position);
    end else if (i_tick) begin
      tick_upd_d  = 1'b1;
      time_d.sec  = sec_wrap ? '0 : time_q.sec + 1'b1;
      if (sec_wrap) time_d.min  = min_wrap ? '0 : time_q.min + 1'b1;
      if (min_wrap) time_d.hour = hour_wrap ? '0 : time_q.hour + 1'b1;
      day_hit_d   = hour_wrap;
    end

    if (mode == MODE_ALARM && i_inc) begin
      for (int k = 0; k < N_ALARM; k++)
        if (int'(i_alarm_sel) == k) alarm_d[k] = edit_field(alarm_q[k], i_position);
    end
  end

`ifdef HMS_SNOOZE_EN
  logic [N_ALARM-1:0] snooze_mask_q, snooze_mask_d;
  logic [15:0]        snooze_cnt_q, snooze_cnt_d;
`else
  logic unused_snooze;
  assign unused_snooze = ^{i_snooze, 16'(SNOOZE_SEC)};
`endif

  // Clears are applied first and sets last, so a coincident set wins.
  always_comb begin
    flags_d = flags_q;
    if (i_alarm_clr) flags_d = '0;
    flags_d = flags_d & i_alarm_en;
`ifdef HMS_SNOOZE_EN
    snooze_mask_d = snooze_mask_q;
    snooze_cnt_d  = snooze_cnt_q;
    if (i_snooze && |flags_q) begin
      snooze_mask_d = flags_q;
      snooze_cnt_d  = 16'(SNOOZE_SEC);
      flags_d       = '0;
    end else if (|snooze_mask_q && i_tick) begin
      if (snooze_cnt_q <= 16'd1) begin
        flags_d       = flags_d | (snooze_mask_q & i_alarm_en);
        snooze_mask_d = '0;
        snooze_cnt_d  = '0;
      end else begin
        snooze_cnt_d  = snooze_cnt_q - 16'd1;
      end
    end
    if (i_alarm_clr) begin
      snooze_mask_d = '0;
      snooze_cnt_d  = '0;
    end
`endif
    if (tick_upd_q) begin
      for (int k = 0; k < N_ALARM; k++)
        if (i_alarm_en[k] && time_q == alarm_q[k]) flags_d[k] = 1'b1;
    end
  end

  // NOTE: the alarm register array is small and must read 0 after reset, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q     <= '0;
      tick_upd_q <= 1'b0;
      day_hit_q  <= 1'b0;
      flags_q    <= '0;
      for (int k = 0; k < N_ALARM; k++) alarm_q[k] <= '0;
`ifdef HMS_SNOOZE_EN
      snooze_mask_q <= '0;
      snooze_cnt_q  <= '0;
`endif
    end else begin
      time_q     <= time_d;
      tick_upd_q <= tick_upd_d;
      day_hit_q  <= day_hit_d;
      flags_q    <= flags_d;
      for (int k = 0; k < N_ALARM; k++) alarm_q[k] <= alarm_d[k];
`ifdef HMS_SNOOZE_EN
      snooze_mask_q <= snooze_mask_d;
      snooze_cnt_q  <= snooze_cnt_d;
`endif
    end
  end

  hms_t disp;
  always_comb begin
    disp = '0;
    if (mode == MODE_ALARM) begin
      for (int k = 0; k < N_ALARM; k++)
        if (int'(i_alarm_sel) == k) disp = alarm_q[k];
    end else begin
      disp = time_q;
    end
  end

  assign o_sec       = disp.sec;
  assign o_min       = disp.min;
  assign o_hour      = disp.hour;
  assign o_day_hit   = day_hit_q;
  assign o_alarm     = flags_q;
  assign o_alarm_any = |flags_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Self-checking bench for hms_timekeeper: directed vector table plus hand-written alarm/carry sequences.
module tb_hms_timekeeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_tick = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic [1:0] i_position = 2'd3;
  logic       i_inc = 1'b0;
  logic [0:0] i_alarm_sel = 1'b0;
  logic [1:0] i_alarm_en = 2'b00;
  logic       i_alarm_clr = 1'b0;
  logic       i_snooze = 1'b0;
  logic [5:0] o_sec, o_min, o_hour;
  logic       o_day_hit;
  logic [1:0] o_alarm;
  logic       o_alarm_any;

  int n_cmp = 0;
  int n_err = 0;

  hms_timekeeper #(.SNOOZE_SEC(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick      (i_tick),
    .i_mode      (i_mode),
    .i_position  (i_position),
    .i_inc       (i_inc),
    .i_alarm_sel (i_alarm_sel),
    .i_alarm_en  (i_alarm_en),
    .i_alarm_clr (i_alarm_clr),
    .i_snooze    (i_snooze),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
    .o_day_hit   (o_day_hit),
    .o_alarm     (o_alarm),
    .o_alarm_any (o_alarm_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] pos;
    logic       sel;
    logic       inc;
    logic       tick;
    logic [5:0] h, m, s;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_hms(input string name, input int h, input int m, input int s);
    check({name, ".hour"}, 32'(o_hour), 32'(h));
    check({name, ".min"},  32'(o_min),  32'(m));
    check({name, ".sec"},  32'(o_sec),  32'(s));
  endtask

  task automatic check_alarm(input string name, input logic [1:0] exp);
    check({name, ".alarm"}, 32'(o_alarm), 32'(exp));
    check({name, ".any"},   32'(o_alarm_any), 32'(|exp));
  endtask

  // One clock edge with the given single-cycle pulses; returns 1 ns after the edge.
  task automatic cyc(input logic tick, input logic inc, input logic clr, input logic snz);
    i_tick = tick; i_inc = inc; i_alarm_clr = clr; i_snooze = snz;
    @(posedge clk); #1;
    i_tick = 1'b0; i_inc = 1'b0; i_alarm_clr = 1'b0; i_snooze = 1'b0;
  endtask

  task automatic edit(input logic [1:0] mode, input logic sel, input logic [1:0] pos, input int n);
    i_mode = mode; i_alarm_sel = sel; i_position = pos;
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_hms(name, 0, 0, 0);
    check({name, ".day_hit"}, 32'(o_day_hit), 32'd0);
    check_alarm(name, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    i_mode = 2'd0; i_alarm_en = 2'b00; i_alarm_sel = 1'b0; i_position = 2'd3;
    @(posedge clk); #1;
  endtask

  initial begin
    //          mode  pos   sel   inc   tick  h  m  s
    vecs[0]  = '{2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1};
    vecs[1]  = '{2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 0, 1, 1};
    vecs[2]  = '{2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1, 1, 1};
    vecs[3]  = '{2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 1, 1, 1};
    vecs[4]  = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1, 1, 1};
    vecs[5]  = '{2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1, 1, 1};
    vecs[6]  = '{2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1, 1, 1};
    vecs[7]  = '{2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1, 1, 2};
    vecs[8]  = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1, 1, 3};
    vecs[9]  = '{2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1};
    vecs[10] = '{2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 1, 0, 0};
    vecs[11] = '{2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 0, 0, 1};
    vecs[12] = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1, 1, 4};

    // Reset state and basic counting with carries.
    do_reset("reset");
    repeat (59) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_hms("count59", 0, 0, 59);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_hms("count60", 0, 1, 0);
    repeat (3540) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_hms("count3600", 1, 0, 0);
    check("count3600.day_hit", 32'(o_day_hit), 32'd0);

    // Table: setup edits, frozen time, ignored inc, mode 3 counting, alarm display.
    do_reset("reset_tbl");
    for (int i = 0; i < 13; i++) begin
      i_mode = vecs[i].mode; i_position = vecs[i].pos; i_alarm_sel = vecs[i].sel;
      cyc(vecs[i].tick, vecs[i].inc, 1'b0, 1'b0);
      check_hms($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("vec%0d.day_hit", i), 32'(o_day_hit), 32'd0);
    end

    // Day rollover from 23:59:59 in one edge, o_day_hit for exactly one cycle.
    do_reset("reset_day");
    edit(2'd1, 1'b0, 2'd2, 23);
    edit(2'd1, 1'b0, 2'd1, 59);
    edit(2'd1, 1'b0, 2'd0, 59);
    check_hms("set235959", 23, 59, 59);
    check("set235959.day_hit", 32'(o_day_hit), 32'd0);
    i_mode = 2'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_hms("rollover", 0, 0, 0);
    check("rollover.day_hit", 32'(o_day_hit), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rollover.day_hit_drop", 32'(o_day_hit), 32'd0);

    // Setup minute wrap without carry; ticks ignored while in setup.
    edit(2'd1, 1'b0, 2'd2, 5);
    edit(2'd1, 1'b0, 2'd1, 59);
    check_hms("setup_min59", 5, 59, 0);
    edit(2'd1, 1'b0, 2'd1, 1);
    check_hms("setup_minwrap", 5, 0, 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_hms("setup_frozen", 5, 0, 0);

    // Alarm fires one clock after the tick, is sticky, clears, and does not re-fire.
    do_reset("reset_alm");
    edit(2'd2, 1'b0, 2'd0, 5);
    check_hms("alm0_disp", 0, 0, 5);
    i_alarm_en = 2'b01; i_mode = 2'd0;
    for (int t = 1; t <= 5; t++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (t < 5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_hms("alm_tick5", 0, 0, 5);
    check_alarm("alm_tick5", 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("alm_fire", 2'b01);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("alm_hold", 2'b01);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_alarm("alm_clr", 2'b00);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("alm_norefire", 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_hms("alm_tick6", 0, 0, 6);
    check_alarm("alm_tick6", 2'b00);

    // Set and clear on the same edge: set wins. Then reset while the alarm is held.
    edit(2'd2, 1'b0, 2'd0, 3);
    i_mode = 2'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_alarm("set_wins", 2'b01);
    do_reset("reset_mid_alarm");

    // Two channels at same time, only the enabled one fires; enable drop clears; edits never fire.
    edit(2'd2, 1'b0, 2'd0, 3);
    edit(2'd2, 1'b1, 2'd0, 3);
    check_hms("alm1_disp", 0, 0, 3);
    i_alarm_en = 2'b01; i_mode = 2'd0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("chan_sel", 2'b01);
    i_alarm_en = 2'b00;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("en_drop", 2'b00);
    i_alarm_en = 2'b01;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("tick4_nofire", 2'b00);
    edit(2'd2, 1'b0, 2'd0, 1);
    check_hms("alm0_eq_time", 0, 0, 4);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("edit_nofire", 2'b00);

    // Snooze: suppress and restore after three ticks when built in, otherwise ignored.
    do_reset("reset_snz");
    edit(2'd2, 1'b0, 2'd0, 2);
    i_alarm_en = 2'b01; i_mode = 2'd0;
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_alarm("snz_fire", 2'b01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef HMS_SNOOZE_EN
    check_alarm("snz_off", 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_alarm("snz_tick2", 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_alarm("snz_restore", 2'b01);
`else
    check_alarm("snz_ignored", 2'b01);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_alarm("snz_ignored_hold", 2'b01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
